// File: rtl/dc_bus_pkg.sv
// Shared types and constants for the data-memory bus responders.
// Holds the VRAM responder state encoding and the word-half selection helpers.
package dc_bus_pkg;

    localparam int DM_DATA_W   = 64;
    localparam int VRAM_DATA_W = 32;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LO_ISSUE = 3'd1,
        LO_WAIT  = 3'd2,
        HI_ISSUE = 3'd3,
        HI_WAIT  = 3'd4,
        RESP     = 3'd5
    } dm_state_e;

    function automatic logic [VRAM_DATA_W-1:0] half_word(input logic [DM_DATA_W-1:0] data,
                                                         input logic half);
        return half ? data[63:32] : data[31:0];
    endfunction

    function automatic logic [3:0] half_mask(input logic [7:0] mask, input logic half);
        return half ? mask[7:4] : mask[3:0];
    endfunction

endpackage

// File: rtl/dm_vram_responder.sv
// Serves 64-bit data-memory requests in the VRAM window as one or two 32-bit
// VRAM beats, returning a one-cycle completion pulse and the assembled read data.
module dm_vram_responder
    import dc_bus_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 23
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   sel,
    input  logic                   dm_req_valid,
    input  logic [31:0]            dm_req_addr,
    input  logic                   dm_req_wen,
    input  logic [DM_DATA_W-1:0]   dm_req_wdata,
    input  logic [7:0]             dm_req_wmask,
    output logic                   dm_resp_valid,
    output logic [DM_DATA_W-1:0]   dm_resp_rdata,
    output logic [ADDR_W-1:0]      vram_addr,
    output logic                   vram_rd,
    output logic                   vram_wr,
    output logic [3:0]             vram_be,
    output logic [VRAM_DATA_W-1:0] vram_dout,
    input  logic [VRAM_DATA_W-1:0] vram_din,
    input  logic                   vram_busy
);

    // The wait states last RD_LATENCY cycles: load L-1, capture when the count hits zero.
    localparam logic [2:0] CNT_LOAD = 3'(RD_LATENCY - 1);

    dm_state_e              state_q, state_d;
    logic [ADDR_W-4:0]      addr_q, addr_d;
    logic                   wen_q, wen_d;
    logic [DM_DATA_W-1:0]   wdata_q, wdata_d;
    logic [7:0]             wmask_q, wmask_d;
    logic [VRAM_DATA_W-1:0] lo_q, lo_d;
    logic [DM_DATA_W-1:0]   rdata_q, rdata_d;
    logic [2:0]             cnt_q, cnt_d;

    logic issue;
    logic half;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{dm_req_addr[31:ADDR_W], dm_req_addr[2:0]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        lo_d          = lo_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        issue         = 1'b0;
        half          = HALF_LO;
        dm_resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm_req_valid && sel) begin
                    addr_d  = dm_req_addr[ADDR_W-1:3];
                    wen_d   = dm_req_wen;
                    wdata_d = dm_req_wdata;
                    wmask_d = dm_req_wmask;
                    if (!dm_req_wen || (|dm_req_wmask[3:0])) begin
                        state_d = LO_ISSUE;
                    end else if (|dm_req_wmask[7:4]) begin
                        state_d = HI_ISSUE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            LO_ISSUE: begin
                issue = 1'b1;
                half  = HALF_LO;
                if (!vram_busy) begin
                    if (!wen_q) begin
                        state_d = LO_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = (|wmask_q[7:4]) ? HI_ISSUE : RESP;
                    end
                end
            end
            LO_WAIT: begin
                if (cnt_q == 3'd0) begin
                    lo_d    = vram_din;
                    state_d = HI_ISSUE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HI_ISSUE: begin
                issue = 1'b1;
                half  = HALF_HI;
                if (!vram_busy) begin
                    if (!wen_q) begin
                        state_d = HI_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            HI_WAIT: begin
                // Loading here makes the new data visible during the RESP cycle.
                if (cnt_q == 3'd0) begin
                    rdata_d = {vram_din, lo_q};
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                dm_resp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vram_addr = '0;
        vram_rd   = 1'b0;
        vram_wr   = 1'b0;
        vram_be   = 4'h0;
        vram_dout = '0;
        if (issue) begin
            vram_addr = {addr_q, half, 2'b00};
            vram_rd   = !wen_q;
            vram_wr   = wen_q;
            vram_be   = wen_q ? half_mask(wmask_q, half) : 4'hF;
            vram_dout = wen_q ? half_word(wdata_q, half) : '0;
        end
    end

    assign dm_resp_rdata = rdata_q;

endmodule

// File: doc/dm_vram_responder.md
Name: dm_vram_responder

Overview:
- Memory-side responder for the core's 64-bit data-memory request/response interface (dm_req_* / dm_resp_*), serving the VRAM address windows.
- Splits each 64-bit access into one or two 32-bit VRAM beats on a byte-addressed 32-bit VRAM port.
- Returns read data with a single-cycle dm_resp_valid pulse.
- Sits between the top-level address decode (sel) and the external VRAM model.

Parameters:
- RD_LATENCY, 2, cycles from accepted vram_rd to valid vram_din (legal range 1..8).
- ADDR_W, 23, VRAM byte-address width.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset; asynchronous assert, active-low.
- sel  in  1  decoded VRAM window hit; qualifies dm_req_valid.
- dm_req_valid  in  1  request present; requester holds all dm_req_* stable until dm_resp_valid.
- dm_req_addr  in  32  byte address; bits [ADDR_W-1:3] used.
- dm_req_wen  in  1  1 = write, 0 = read.
- dm_req_wdata  in  64  write data, little-endian (bits [31:0] = low word).
- dm_req_wmask  in  8  byte enables; bits [3:0] = low word.
- dm_resp_valid  out  1  one-cycle completion pulse (reads and writes).
- dm_resp_rdata  out  64  read data; held until the next read completes.
- vram_addr  out  ADDR_W  word-aligned byte address of the current beat.
- vram_rd  out  1  read strobe.
- vram_wr  out  1  write strobe.
- vram_be  out  4  beat byte enables.
- vram_dout  out  32  beat write data.
- vram_din  in  32  read data.
- vram_busy  in  1  beat not accepted this cycle.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FSM goes to IDLE.
  - All outputs and the rdata/capture registers are cleared to 0.
  - Any in-flight transaction is discarded and no response is issued.
- Accept: in IDLE, at the first clock edge with dm_req_valid && sel. The request is latched internally; the live inputs are not used afterwards.
- States:
  - IDLE
  - LO_ISSUE: vram_addr = {addr[ADDR_W-1:3], 3'b000}; low data and mask.
  - LO_WAIT
  - HI_ISSUE: vram_addr = low address + 4; high data and mask.
  - HI_WAIT
  - RESP
- Issue states:
  - Strobe held high with stable addr/be/dout until a cycle with vram_busy = 0; that cycle is the accept cycle.
  - vram_be = 4'hF on reads.
- Reads:
  - Both halves are always fetched.
  - WAIT counts RD_LATENCY cycles after the accept cycle N, then vram_din is captured in cycle N+RD_LATENCY.
  - LO_WAIT → HI_ISSUE; HI_WAIT → RESP.
- Writes:
  - No WAIT states.
  - A half whose 4 mask bits are all zero is skipped: no strobe for that half.
  - If wmask == 0, go straight to RESP with no VRAM activity.
- RESP:
  - dm_resp_valid = 1 for exactly one cycle, then IDLE.
  - For reads, dm_resp_rdata is updated in the same cycle to {hi, lo}.
  - A new request can be accepted in the cycle after RESP.
- Timing with no busy (T = accept edge, L = RD_LATENCY):
  - Read: lo issue at T+1, hi issue at T+2+L, response at T+3+2L.
  - Full write: response at T+3.
  - Single-half write: response at T+2.
- Strobe exclusivity: vram_rd and vram_wr are never both high; both are low outside the issue states.
- Request withdrawal: if dm_req_valid drops mid-transaction, the transaction still completes and pulses the response.
- Unselected requests: dm_req_valid with sel = 0 is ignored.
- Address bits [2:0]: ignored.
- Write data: dm_resp_rdata is unchanged by writes.

Decomposition:
- Package dc_bus_pkg holds:
  - state enum (IDLE, LO_ISSUE, LO_WAIT, HI_ISSUE, HI_WAIT, RESP)
  - half-select constants (HALF_LO = 0, HALF_HI = 1)
  - DM_DATA_W = 64, VRAM_DATA_W = 32
- Single module, no sub-module. The latency counter is a 3-bit down-counter inline.

Test Plan:
- Read, L = 2, no busy, addr 0x0500_0010, VRAM words at 0x10 = 0x1111_2222 and 0x14 = 0x3333_4444 → vram_rd at T+1 addr 0x10 and at T+4 addr 0x14; dm_resp_valid only at T+7 with rdata 0x3333_4444_1111_2222.
- Write addr 0x0400_0008, wdata 0xAABBCCDD_11223344, wmask 0xF0 → single vram_wr at T+1, addr 0x0C, be 0xF, dout 0xAABBCCDD; response at T+2.
- Write with wmask 0x00 → no VRAM strobes; dm_resp_valid at T+1.
- vram_busy high for 3 cycles during the lo read issue → vram_rd held 4 cycles with stable addr; capture L cycles after the first non-busy cycle; response delayed by exactly 3 cycles versus the no-busy case.
- reset_n pulsed low during HI_WAIT → outputs 0 immediately without a clock edge; no dm_resp_valid; next request handled normally.
- Back-to-back write then read with sel toggling; dm_req_valid with sel = 0 → no strobes, no response; rdata unchanged after the write.
